// File: rtl/sram_pkg.sv
// ==== sram_pkg: shared state encoding and sizing helpers for sram_bank (rev 1.0) ====
`default_nettype none

package sram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // A one-word bank still needs a 1-bit counter/index.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rd_pipe.sv
// ==== sram_rd_pipe: STAGES-deep delay line for {valid, err, data} read responses (rev 1.0) ====
`default_nettype none

module sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst;
      assign out_valid     = in_valid;
      assign out_err       = in_err;
      assign out_data      = in_data;
    end else begin : g_stages
      logic [STAGES-1:0]             vld_q, vld_d;
      logic [STAGES-1:0]             err_q, err_d;
      logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
      logic [STAGES:0]               vld_c, err_c;
      logic [STAGES:0][DATA_W-1:0]   data_c;

      assign vld_c  = {vld_q, in_valid};
      assign err_c  = {err_q, in_err};
      assign data_c = {data_q, in_data};

      // Data only advances with a valid beat so the output holds between responses.
      always_comb begin
        vld_d  = '0;
        err_d  = '0;
        data_d = data_q;
        for (int i = 0; i < STAGES; i++) begin
          vld_d[i] = vld_c[i];
          err_d[i] = vld_c[i] & err_c[i];
          if (vld_c[i]) begin
            data_d[i] = data_c[i];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= '0;
          err_q  <= '0;
          data_q <= '0;
        end else begin
          vld_q  <= vld_d;
          err_q  <= err_d;
          data_q <= data_d;
        end
      end

      assign out_valid = vld_q[STAGES-1];
      assign out_err   = err_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sram_bank.sv
// ==== sram_bank: single-port SRAM bank, byte strobes, RD_LAT pipeline, zeroing walk (rev 1.0) ====
`default_nettype none

module sram_bank
  import sram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 16384,
  parameter int ADDR_W         = 16,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DATA_W/8-1:0]  req_be,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int               BE_W      = be_width(DATA_W);
  localparam int               CNT_W     = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam state_e           RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  localparam logic             RST_BUSY  = (CLEAR_ON_RESET != 0);

  reg [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              hs;
  logic              in_range;
  logic [CNT_W-1:0]  idx;

  assign hs       = req_valid && ready_q;
  assign in_range = {1'b0, req_addr} < DEPTH_EXT;
  assign idx      = req_addr[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = READY;
        clr_cnt_d = '0;
      end
    end
    // Ready/busy are registered copies of the next state.
    ready_d = (state_d == READY);
    busy_d  = (state_d == CLEAR);

    rd_vld_d  = hs && !req_we;
    rd_err_d  = rd_vld_d && !in_range;
    rd_data_d = rd_data_q;
    if (rd_vld_d) begin
      rd_data_d = in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= RST_BUSY;
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      rd_vld_q  <= rd_vld_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Array has no reset; the clear walk is the only zeroing mechanism.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (hs && req_we && in_range) begin
      for (int k = 0; k < BE_W; k++) begin
        if (req_be[k]) begin
          mem[idx][k*8 +: 8] <= req_wdata[k*8 +: 8];
        end
      end
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_q),
    .in_err    (rd_err_q),
    .in_data   (rd_data_q),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_rdata)
  );

  assign req_ready = ready_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bank.sv
// ==== tb_sram_bank: three sram_bank instances (RD_LAT 1..3) against a word-array model (rev 1.0) ====
`default_nettype none

module tb_sram_bank;

  localparam int DEPTH  = 100;
  localparam int ADDR_W = 8;
  localparam int NDUT   = 3;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [3:0]        req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic [NDUT-1:0]   req_ready_w;
  logic [NDUT-1:0]   rsp_valid_w;
  logic [NDUT-1:0]   rsp_err_w;
  logic [NDUT-1:0]   busy_w;
  logic [31:0]       rdata_w [NDUT];

  logic [31:0]       model [DEPTH];
  exp_t              exp_q [NDUT][$];
  logic [31:0]       last_data [NDUT];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                nbusy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sram_bank #(
        .DATA_W         (32),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .RD_LAT         (g + 1),
        .CLEAR_ON_RESET (1)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready_w[g]),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_w[g]),
        .rsp_rdata (rdata_w[g]),
        .rsp_err   (rsp_err_w[g]),
        .busy      (busy_w[g])
      );
    end
  endgenerate

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: pops one expectation per rsp_valid, per instance.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst) begin
        chk({rsp_valid_w[d], rsp_err_w[d], rdata_w[d]} == '0,
            $sformatf("reset_outputs_lat%0d", d + 1),
            {rsp_valid_w[d], rsp_err_w[d], rdata_w[d]}, 0);
        last_data[d] = '0;
      end else if (rsp_valid_w[d]) begin
        if (exp_q[d].size() == 0) begin
          chk(1'b0, $sformatf("unexpected_rsp_lat%0d", d + 1), rdata_w[d], 0);
        end else begin
          exp_t e;
          e = exp_q[d].pop_front();
          chk(rdata_w[d] == e.data, $sformatf("rsp_data_lat%0d", d + 1), rdata_w[d], e.data);
          chk(rsp_err_w[d] == e.err, $sformatf("rsp_err_lat%0d", d + 1), rsp_err_w[d], e.err);
          chk(cyc == e.due, $sformatf("rsp_cycle_lat%0d", d + 1), cyc, e.due);
        end
        last_data[d] = rdata_w[d];
      end else begin
        chk(!rsp_err_w[d] && rdata_w[d] == last_data[d],
            $sformatf("idle_hold_lat%0d", d + 1),
            {rsp_err_w[d], rdata_w[d]}, {1'b0, last_data[d]});
        if (exp_q[d].size() > 0 && exp_q[d][0].due < cyc) begin
          chk(1'b0, $sformatf("missing_rsp_lat%0d", d + 1), cyc, exp_q[d][0].due);
          void'(exp_q[d].pop_front());
        end
      end
    end
  end

  // One request slot: drive after the edge, update the model, queue read expectations.
  task automatic drive(input bit v, input bit we, input logic [3:0] be,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    if (v) begin
      chk(req_ready_w == {NDUT{1'b1}}, "req_ready", req_ready_w, {NDUT{1'b1}});
      if (we) begin
        if (addr < DEPTH) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) model[addr][k*8 +: 8] = wd[k*8 +: 8];
          end
        end
      end else begin
        for (int d = 0; d < NDUT; d++) begin
          exp_q[d].push_back('{due: cyc + d + 1,
                               data: (addr < DEPTH) ? model[addr] : 32'h0,
                               err: (addr >= DEPTH)});
        end
      end
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [3:0] be);
    drive(1'b1, 1'b1, be, a, wd);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    drive(1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, '0, 32'h0);
  endtask

  // Called right after reset release; counts busy cycles, bounded.
  task automatic count_busy(output int n);
    int viol;
    viol = 0;
    n    = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_w == {NDUT{1'b1}}) begin
        n++;
        if (req_ready_w != '0) viol++;
      end else begin
        break;
      end
    end
    req_valid = 1'b0;
    chk(viol == 0, "ready_during_clear", viol, 0);
    chk(n == DEPTH, "busy_cycles", n, DEPTH);
    chk(busy_w == '0, "busy_after_clear", busy_w, 0);
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    zero_model();

    repeat (3) @(posedge clk);
    #1;
    chk(busy_w == {NDUT{1'b1}}, "busy_in_reset", busy_w, {NDUT{1'b1}});
    chk(req_ready_w == '0, "ready_in_reset", req_ready_w, 0);

    // A write held on the port during the walk must not land.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = '0;
    req_wdata = 32'hFFFF_FFFF;
    rst       = 1'b1;
    count_busy(nbusy);

    rd(0);
    for (int a = 0; a < DEPTH; a++) wr(ADDR_W'(a), 32'hFFFF_FFFF, 4'hF);
    wr(ADDR_W'(100), 32'hDEAD_BEEF, 4'hF);
    wr(5, 32'h1122_3344, 4'b1111);
    wr(5, 32'hAABB_CCDD, 4'b0101);
    rd(5);
    wr(7, 32'hCAFE_F00D, 4'hF);
    rd(7);
    for (int a = 0; a < 8; a++) rd(ADDR_W'(a));
    rd(100);
    rd(99);
    wr(3, 32'h1234_5678, 4'h0);
    rd(3);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
            ADDR_W'($urandom_range(0, 127)), $urandom);
    end
    idle(6);

    // Two reads in flight, then reset: nothing may emerge afterwards.
    rd(10);
    rd(11);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_q[d].delete();
    zero_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (DEPTH / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    count_busy(nbusy);

    for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a));
    idle(8);

    for (int d = 0; d < NDUT; d++) begin
      chk(exp_q[d].size() == 0, $sformatf("drained_lat%0d", d + 1), exp_q[d].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
